// File: rtl/intctrl.sv
// Interrupt controller: edge/level request capture, software mask, CPU gate and a registered
// priority-encoded vector, with a small Wishbone slave for register access.
module intctrl #(
   parameter int unsigned NSRC      = 7,
   parameter logic [6:0]  LEVEL_MSK = 7'h40,
   parameter logic [6:0]  MASK_RST  = 7'h7F
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            cyc_i,
   input  logic            stb_i,
   input  logic            we_i,
   input  logic [1:0]      adr_i,
   input  logic [3:0]      sel_i,
   input  logic [31:0]     dat_i,
   output logic [31:0]     dat_o,
   output logic            ack_o,
   input  logic [NSRC-1:0] src_i,
   input  logic            int_en_i,
   output logic [2:0]      inter_o,
   output logic            irq_o
);

   // The vector is three bits wide, so at most seven sources can be encoded.
   if (NSRC < 1 || NSRC > 7) begin : g_nsrc_check
      $error("intctrl: NSRC must be in the range 1..7");
   end

   localparam logic [NSRC-1:0] LVL  = LEVEL_MSK[NSRC-1:0];
   localparam logic [NSRC-1:0] MRST = MASK_RST[NSRC-1:0];

   typedef enum logic {StIdle, StAck} bus_state_e;

   bus_state_e      state_q;
   logic [NSRC-1:0] src_q, src_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [2:0]      inter_q, inter_d;
   logic            irq_q, irq_d;
   logic [NSRC-1:0] req, edge_set, w1c;
   logic            bus_req, wr_commit;
   logic [31:0]     rd_data;
   logic            unused_bits;

   assign unused_bits = ^{sel_i[3:1], dat_i};

   always_comb begin
      bus_req   = cyc_i & stb_i & (state_q == StIdle);
      wr_commit = bus_req & we_i & sel_i[0];
      w1c       = (wr_commit && adr_i == 2'd0) ? dat_i[NSRC-1:0] : '0;
      edge_set  = src_i & ~src_q;
      src_d     = src_i;
      // A new edge beats a same-cycle clear; level sources simply follow the input.
      pend_d    = ((edge_set | (pend_q & ~w1c)) & ~LVL) | (src_i & LVL);
      mask_d    = (wr_commit && adr_i == 2'd1) ? dat_i[NSRC-1:0] : mask_q;

      req     = pend_q & mask_q;
      inter_d = 3'd0;
      if (int_en_i) begin
         for (int i = 0; i < int'(NSRC); i++) begin
            if (req[i]) inter_d = 3'(i + 1);
         end
      end
      irq_d = (inter_d != 3'd0);

      case (adr_i)
         2'd0:    rd_data = 32'(pend_q);
         2'd1:    rd_data = 32'(mask_q);
         2'd2:    rd_data = {28'b0, irq_q, inter_q};
         default: rd_data = 32'(src_q);
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         src_q   <= '0;
         pend_q  <= '0;
         mask_q  <= MRST;
         inter_q <= 3'd0;
         irq_q   <= 1'b0;
      end else begin
         src_q   <= src_d;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
         inter_q <= inter_d;
         irq_q   <= irq_d;
      end
   end

   assign inter_o = inter_q;
   assign irq_o   = irq_q;

   // Bus FSM: commits or captures read data on the IDLE->ACK edge, then acks for one cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         ack_o   <= 1'b0;
         dat_o   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus_req) begin
                  state_q <= StAck;
                  ack_o   <= 1'b1;
                  dat_o   <= we_i ? '0 : rd_data;
               end else begin
                  ack_o <= 1'b0;
                  dat_o <= '0;
               end
            end
            StAck: begin
               state_q <= StIdle;
               ack_o   <= 1'b0;
               dat_o   <= '0;
            end
         endcase
      end
   end

endmodule
